// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared types and constants for the instruction-fetch stage
package if_pkg;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    HOLD     = 2'd1,
    REDIRECT = 2'd2
  } if_state_e;

  localparam logic [31:0] NOP                  = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_pc_reg.sv
// rtl/if_pc_reg.sv - program counter with next-PC select (jump > branch > +4 > hold)
module if_pc_reg
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        i_jump,
  input  logic [31:0] i_jump_target,
  input  logic        i_branch,
  input  logic [31:0] i_branch_target,
  input  logic        i_advance,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4
);

  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_pc_plus4;

  // Plain 32-bit add: wraps from 0xFFFF_FFFC to 0 by truncation.
  assign w_pc_plus4 = r_pc + 32'd4;

  always_comb begin
    w_pc_nxt = r_pc;
    if (i_jump) begin
      w_pc_nxt = align_word(i_jump_target);
    end else if (i_branch) begin
      w_pc_nxt = align_word(i_branch_target);
    end else if (i_advance) begin
      w_pc_nxt = w_pc_plus4;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_pc <= RESET_VECTOR;
    end else begin
      r_pc <= w_pc_nxt;
    end
  end

  assign o_pc       = r_pc;
  assign o_pc_plus4 = w_pc_plus4;

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction-fetch stage: fetch FSM, instruction capture, redirect flush
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        PCWrite,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic        Branch,
  input  logic [31:0] BranchTarget,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic        IMemReady,
  input  logic [31:0] IMemData,
  output logic [31:0] Instr,
  output logic [31:0] PC_4,
  output logic        InstrValid,
  output logic        IFFlush
);

  if_state_e   r_state;
  if_state_e   w_state_nxt;
  logic [31:0] r_instr;
  logic [31:0] r_pc_4;
  logic        r_valid;
  logic        r_flush;

  logic        w_redirect;
  logic        w_fetch;
  logic        w_capture;
  logic        w_advance;
  logic [31:0] w_pc;
  logic [31:0] w_pc_plus4;

  assign w_redirect = Jump | Branch;
  assign w_fetch    = (r_state == FETCH);
  // A redirect in the same cycle as IMemReady throws the returned word away.
  assign w_capture  = w_fetch & IMemReady & ~w_redirect;
  assign w_advance  = PCWrite & (w_capture | (r_state == HOLD));

  if_pc_reg #(
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc_reg (
    .CLK             (CLK),
    .RST_N           (RST_N),
    .i_jump          (Jump),
    .i_jump_target   (JumpTarget),
    .i_branch        (Branch),
    .i_branch_target (BranchTarget),
    .i_advance       (w_advance),
    .o_pc            (w_pc),
    .o_pc_plus4      (w_pc_plus4)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (w_redirect) begin
      w_state_nxt = REDIRECT;
    end else begin
      case (r_state)
        FETCH:    if (IMemReady && !PCWrite) w_state_nxt = HOLD;
        HOLD:     if (PCWrite) w_state_nxt = FETCH;
        REDIRECT: w_state_nxt = FETCH;
        default:  w_state_nxt = FETCH;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= REDIRECT;
      r_instr <= NOP;
      r_pc_4  <= 32'h0000_0000;
      r_valid <= 1'b0;
      r_flush <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_flush <= w_redirect;
      if (w_redirect) begin
        r_instr <= NOP;
        r_valid <= 1'b0;
      end else if (w_capture) begin
        r_instr <= IMemData;
        r_pc_4  <= w_pc_plus4;
        r_valid <= 1'b1;
      end
    end
  end

  assign IMemReq    = w_fetch;
  assign IMemAddr   = w_pc;
  assign Instr      = r_instr;
  assign PC_4       = r_pc_4;
  assign InstrValid = r_valid;
  assign IFFlush    = r_flush;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard bench for if_stage
module tb_if_stage;

  logic        CLK;
  logic        RST_N;
  logic        PCWrite;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic        Branch;
  logic [31:0] BranchTarget;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemReady;
  logic [31:0] IMemData;
  logic [31:0] Instr;
  logic [31:0] PC_4;
  logic        InstrValid;
  logic        IFFlush;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] addr;
    bit          discard;
  } exp_t;

  exp_t q[$];
  bit   pend = 0;
  exp_t pend_e;

  if_stage dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .PCWrite      (PCWrite),
    .Jump         (Jump),
    .JumpTarget   (JumpTarget),
    .Branch       (Branch),
    .BranchTarget (BranchTarget),
    .IMemReq      (IMemReq),
    .IMemAddr     (IMemAddr),
    .IMemReady    (IMemReady),
    .IMemData     (IMemData),
    .Instr        (Instr),
    .PC_4         (PC_4),
    .InstrValid   (InstrValid),
    .IFFlush      (IFFlush)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  assign IMemData = mem(IMemAddr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [31:0] addr, input bit discard);
    exp_t e;
    e.addr    = addr;
    e.discard = discard;
    q.push_back(e);
  endtask

  task automatic wait_req(input logic [31:0] addr);
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (IMemReq && IMemAddr == addr) return;
    end
    n_checks++;
    n_errors++;
    $display("FAIL wait_req timeout: no request at %h", addr);
  endtask

  // Inputs change only just after posedge, so the values seen here are the ones the next edge uses.
  always @(negedge CLK) begin
    if (pend) begin
      pend = 0;
      if (pend_e.discard) begin
        check("discard_instr", Instr, 32'h0);
        check("discard_valid", {31'd0, InstrValid}, 32'd0);
      end else begin
        check("cap_instr", Instr, mem(pend_e.addr));
        check("cap_pc4", PC_4, pend_e.addr + 32'd4);
        check("cap_valid", {31'd0, InstrValid}, 32'd1);
      end
    end
    if (RST_N && IMemReq && IMemReady) begin
      if (q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_fetch: got addr %h expected none", IMemAddr);
      end else begin
        pend_e = q.pop_front();
        check("fetch_addr", IMemAddr, pend_e.addr);
        pend = 1;
      end
    end
  end

  initial begin
    RST_N = 1'b0; PCWrite = 1'b1; IMemReady = 1'b1;
    Jump = 1'b0; JumpTarget = 32'h0; Branch = 1'b0; BranchTarget = 32'h0;
    cyc(); cyc();
    check("rst_req", {31'd0, IMemReq}, 32'd0);
    check("rst_addr", IMemAddr, 32'h0);
    check("rst_instr", Instr, 32'h0);
    check("rst_pc4", PC_4, 32'h0);
    check("rst_valid", {31'd0, InstrValid}, 32'd0);
    check("rst_flush", {31'd0, IFFlush}, 32'd0);

    // Sequential fetch from reset
    for (int i = 0; i < 5; i++) push(32'(4 * i), 1'b0);
    RST_N = 1'b1;
    check("release_req", {31'd0, IMemReq}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("seq_req", {31'd0, IMemReq}, 32'd1);
      check("seq_addr", IMemAddr, 32'(4 * i));
      if (i > 0) check("seq_pc4", PC_4, 32'(4 * i));
    end

    // Stall after the fetch at 0x10
    PCWrite = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("hold_req", {31'd0, IMemReq}, 32'd0);
      check("hold_instr", Instr, mem(32'h10));
      check("hold_pc4", PC_4, 32'h14);
      check("hold_addr", IMemAddr, 32'h10);
    end
    push(32'h14, 1'b1);
    PCWrite = 1'b1;
    wait_req(32'h14);

    // Jump and branch together, with data returning in the same cycle
    Jump = 1'b1; JumpTarget = 32'h400; Branch = 1'b1; BranchTarget = 32'h200;
    cyc();
    check("jmp_flush", {31'd0, IFFlush}, 32'd1);
    check("jmp_valid", {31'd0, InstrValid}, 32'd0);
    check("jmp_instr", Instr, 32'h0);
    check("jmp_req", {31'd0, IMemReq}, 32'd0);
    check("jmp_addr", IMemAddr, 32'h400);
    Jump = 1'b0; Branch = 1'b0;
    push(32'h400, 1'b0);
    cyc();
    check("jmp_flush_pulse", {31'd0, IFFlush}, 32'd0);
    check("jmp_fetch_req", {31'd0, IMemReq}, 32'd1);
    check("jmp_fetch_addr", IMemAddr, 32'h400);
    push(32'h404, 1'b1);
    cyc();
    Branch = 1'b1; BranchTarget = 32'h203;
    cyc();
    check("br_flush", {31'd0, IFFlush}, 32'd1);
    check("br_addr", IMemAddr, 32'h200);
    check("br_valid", {31'd0, InstrValid}, 32'd0);
    Branch = 1'b0; IMemReady = 1'b0;
    push(32'h200, 1'b0);

    // Memory not ready: request and address stay put
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("wait_req", {31'd0, IMemReq}, 32'd1);
      check("wait_addr", IMemAddr, 32'h200);
      check("wait_instr", Instr, 32'h0);
      check("wait_flush", {31'd0, IFFlush}, 32'd0);
    end
    IMemReady = 1'b1;
    push(32'h204, 1'b1);
    cyc();

    // Redirects back to back while in REDIRECT
    Jump = 1'b1; JumpTarget = 32'h300;
    cyc();
    check("rr_flush1", {31'd0, IFFlush}, 32'd1);
    check("rr_addr1", IMemAddr, 32'h300);
    Jump = 1'b0; Branch = 1'b1; BranchTarget = 32'h500;
    cyc();
    check("rr_flush2", {31'd0, IFFlush}, 32'd1);
    check("rr_addr2", IMemAddr, 32'h500);
    check("rr_req2", {31'd0, IMemReq}, 32'd0);
    Branch = 1'b0; Jump = 1'b1; JumpTarget = 32'hFFFF_FFFF;
    cyc();
    check("wrap_addr", IMemAddr, 32'hFFFF_FFFC);
    Jump = 1'b0;
    push(32'hFFFF_FFFC, 1'b0);
    push(32'h0, 1'b0);
    cyc();
    cyc();
    check("wrap_next_addr", IMemAddr, 32'h0);
    check("wrap_next_req", {31'd0, IMemReq}, 32'd1);
    PCWrite = 1'b0;
    cyc();
    IMemReady = 1'b0; PCWrite = 1'b1;
    cyc();
    check("pre_rst_req", {31'd0, IMemReq}, 32'd1);
    check("pre_rst_addr", IMemAddr, 32'h4);

    // Reset in the middle of an outstanding request
    RST_N = 1'b0;
    #1;
    check("arst_req", {31'd0, IMemReq}, 32'd0);
    check("arst_addr", IMemAddr, 32'h0);
    check("arst_valid", {31'd0, InstrValid}, 32'd0);
    check("arst_instr", Instr, 32'h0);
    IMemReady = 1'b1;
    cyc();
    check("arst_late_ready", {31'd0, IMemReq}, 32'd0);
    push(32'h0, 1'b0);
    RST_N = 1'b1;
    cyc();
    check("post_rst_req", {31'd0, IMemReq}, 32'd1);
    check("post_rst_addr", IMemAddr, 32'h0);
    PCWrite = 1'b0;
    cyc();
    cyc();
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
